// File: rtl/gpio_input.sv
// Memory-mapped single-pin GPIO input: two-flop synchroniser, debounce filter,
// latched rise/fall events with W1C status, and a level interrupt.
module gpio_input #(
  parameter logic [31:0] BASE_ADDR       = 32'h80000010,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          CNT_W           = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  input  logic        gpio_in,
  output logic        irq
);

  localparam logic [31:0]      DATA_ADDR   = BASE_ADDR;
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0]      CTRL_ADDR   = BASE_ADDR + 32'd8;
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             rise_pend;
  logic             fall_pend;
  logic [2:0]       ctrl;
  logic [31:0]      rd_next;

  logic stable_upd;
  logic rise_set;
  logic fall_set;
  logic wr_status;
  logic wr_ctrl;
  logic unused_wd;

  // A level is accepted only after it has differed from stable for DEBOUNCE_CYCLES edges
  assign stable_upd = (sync2 != stable) && (cnt == CNT_MAX);
  assign rise_set   = stable_upd & sync2 & ctrl[0];
  assign fall_set   = stable_upd & ~sync2 & ctrl[1];
  assign wr_status  = WE && (A == STATUS_ADDR);
  assign wr_ctrl    = WE && (A == CTRL_ADDR);
  assign unused_wd  = ^WD[31:3];

  assign irq = ctrl[2] & (rise_pend | fall_pend);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (stable_upd) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A new event on the same edge as a W1C clear takes priority
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rise_pend <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      rise_pend <= rise_set | (rise_pend & ~(wr_status & WD[0]));
      fall_pend <= fall_set | (fall_pend & ~(wr_status & WD[1]));
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ctrl <= 3'b000;
    end else if (wr_ctrl) begin
      ctrl <= WD[2:0];
    end
  end

  always_comb begin
    rd_next = 32'h0;
    case (A)
      DATA_ADDR:   rd_next = {30'h0, sync2, stable};
      STATUS_ADDR: rd_next = {30'h0, fall_pend, rise_pend};
      CTRL_ADDR:   rd_next = {29'h0, ctrl};
      default:     rd_next = 32'h0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      RD <= 32'h0;
    end else begin
      RD <= rd_next;
    end
  end

endmodule

// File: tb/tb_gpio_input.sv
// Bench for gpio_input: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_gpio_input;

  localparam logic [31:0] BASE = 32'h80000010;
  localparam int          DEB  = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] WD = 32'h0;
  logic [31:0] RD;
  logic        gpio_in = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // model state
  bit          pin_h[$];
  bit          s2_h[$];
  logic        m_stable = 1'b0;
  logic        m_rise = 1'b0;
  logic        m_fall = 1'b0;
  logic [2:0]  m_ctrl = 3'b0;
  logic [31:0] m_rd = 32'h0;

  gpio_input #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .WE(WE), .A(A), .WD(WD),
    .RD(RD), .gpio_in(gpio_in), .irq(irq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    pin_h.delete();
    s2_h.delete();
    m_stable = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_ctrl   = 3'b0;
    m_rd     = 32'h0;
  endtask

  // The pin value seen by the filter is the one sampled two edges earlier; the
  // level flips once the last DEB of those values all disagree with it.
  task automatic model_update();
    logic s2;
    logic flip;
    logic set_r;
    logic set_f;
    s2 = (pin_h.size() >= 2) ? pin_h[pin_h.size()-2] : 1'b0;
    pin_h.push_back(gpio_in);
    if (pin_h.size() > 8) void'(pin_h.pop_front());
    s2_h.push_back(s2);
    if (s2_h.size() > DEB) void'(s2_h.pop_front());
    flip = (s2_h.size() == DEB);
    foreach (s2_h[i]) if (s2_h[i] == m_stable) flip = 1'b0;

    if (A == BASE)            m_rd = {30'h0, s2, m_stable};
    else if (A == BASE + 4)   m_rd = {30'h0, m_fall, m_rise};
    else if (A == BASE + 8)   m_rd = {29'h0, m_ctrl};
    else                      m_rd = 32'h0;

    set_r = flip && !m_stable && m_ctrl[0];
    set_f = flip &&  m_stable && m_ctrl[1];
    if (WE && A == BASE + 4) begin
      if (WD[0]) m_rise = 1'b0;
      if (WD[1]) m_fall = 1'b0;
    end
    if (set_r) m_rise = 1'b1;
    if (set_f) m_fall = 1'b1;
    if (flip) m_stable = ~m_stable;
    if (WE && A == BASE + 8) m_ctrl = WD[2:0];
  endtask

  task automatic step(input logic we_v, input logic [31:0] a_v, input logic [31:0] wd_v,
                      input logic pin_v);
    WE = we_v; A = a_v; WD = wd_v; gpio_in = pin_v;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic pin_v);
    #1;
    reset = 1'b1;
    WE = 1'b0; A = 32'h0; WD = 32'h0; gpio_in = pin_v;
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      chk("rd_model", RD, m_rd);
      chk("irq_model", {31'h0, irq}, {31'h0, m_ctrl[2] & (m_rise | m_fall)});
    end
  end

  initial begin : main
    logic [31:0] exp_data [8];
    logic [31:0] addrs [6];
    int run;
    logic lvl;
    exp_data = '{32'h0, 32'h0, 32'h2, 32'h2, 32'h2, 32'h2, 32'h3, 32'h3};
    addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 1, 32'h0};

    @(negedge CLK);
    do_reset(1'b0);

    // reset state
    step(0, BASE, 0, 0);      chk("rst_data", RD, 32'h0);
    step(0, BASE + 4, 0, 0);  chk("rst_status", RD, 32'h0);
    step(0, BASE + 8, 0, 0);  chk("rst_ctrl", RD, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // rising edge accepted exactly 2+DEB edges after first sample
    step(1, BASE + 8, 32'h5, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, BASE, 0, 1);
      chk($sformatf("rise_data_e%0d", k + 1), RD, exp_data[k]);
    end
    step(0, BASE + 4, 0, 1);  chk("rise_status", RD, 32'h1);
    chk("rise_irq", {31'h0, irq}, 32'h1);
    step(1, BASE + 4, 32'h1, 1);
    step(0, BASE + 4, 0, 1);  chk("w1c_status", RD, 32'h0);
    chk("w1c_irq", {31'h0, irq}, 32'h0);

    // glitches shorter than DEB are rejected
    do_reset(1'b0);
    step(1, BASE + 8, 32'h3, 0);
    step(0, BASE, 0, 1);
    repeat (5) step(0, BASE, 0, 0);
    repeat (3) step(0, BASE, 0, 1);
    repeat (6) step(0, BASE, 0, 0);
    chk("glitch_data", RD, 32'h0);
    step(0, BASE + 4, 0, 0);  chk("glitch_status", RD, 32'h0);

    // fall-only enable; W1C on the same edge as a new fall event
    do_reset(1'b0);
    step(1, BASE + 8, 32'h2, 0);
    repeat (8) step(0, BASE, 0, 1);
    chk("fall_hi_data", RD, 32'h3);
    step(0, BASE + 4, 0, 0);
    repeat (4) step(0, BASE, 0, 0);
    step(1, BASE + 4, 32'h2, 0);
    step(0, BASE + 4, 0, 0);  chk("fall_setwins", RD, 32'h2);
    step(1, BASE + 4, 32'h3, 0);
    step(0, BASE + 4, 0, 0);  chk("fall_cleared", RD, 32'h0);

    // irq gated by irq_en, pending bit kept
    do_reset(1'b0);
    step(1, BASE + 8, 32'h1, 0);
    repeat (8) step(0, BASE, 0, 1);
    step(0, BASE + 4, 0, 1);  chk("noirq_status", RD, 32'h1);
    chk("noirq_irq", {31'h0, irq}, 32'h0);
    step(1, BASE + 8, 32'h4, 1);
    chk("irqen_irq", {31'h0, irq}, 32'h1);
    step(0, BASE + 8, 0, 1);  chk("irqen_ctrl", RD, 32'h4);

    // reset mid-debounce, then pin already high after reset
    do_reset(1'b0);
    repeat (4) step(0, BASE, 0, 1);
    do_reset(1'b1);
    step(1, BASE + 8, 32'h1, 1); chk("mid_e1", RD, 32'h0);
    step(0, BASE, 0, 1);      chk("mid_e2_data", RD, 32'h0);
    step(0, BASE, 0, 1);      chk("mid_e3_data", RD, 32'h2);
    repeat (3) begin
      step(0, BASE + 4, 0, 1);
      chk("mid_nopend", RD, 32'h0);
    end
    step(0, BASE + 4, 0, 1);  chk("mid_e7_status", RD, 32'h1);
    step(1, BASE + 12, 32'hFFFFFFFF, 1); chk("bad_addr_wr", RD, 32'h0);
    step(1, BASE + 9, 32'hFFFFFFFF, 1);
    step(0, BASE + 12, 0, 1); chk("bad_addr_rd", RD, 32'h0);
    step(0, BASE + 8, 0, 1);  chk("bad_addr_ctrl", RD, 32'h1);

    // randomized traffic, checked by the model every cycle
    do_reset(1'b0);
    run = 0;
    lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int op;
      if (run == 0) begin
        run = $urandom_range(1, 8);
        lvl = $urandom_range(0, 1);
      end
      run--;
      op = $urandom_range(0, 19);
      if (op == 0 && $urandom_range(0, 9) == 0)
        do_reset(lvl);
      else if (op < 12)
        step(0, addrs[$urandom_range(0, 5)], $urandom, lvl);
      else if (op < 15)
        step(1, BASE + 4, $urandom, lvl);
      else if (op < 18)
        step(1, BASE + 8, $urandom, lvl);
      else
        step(1, addrs[$urandom_range(0, 5)], $urandom, lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
